// File: rtl/fp_norm_pkg.sv
// -----------------------------------------------------------------------------
// fp_norm_pkg
// Shared types and defaults for the floating-point normalization scheduler.
//   - state_e     : controller states (IDLE, DETECT, SHIFT, DONE)
//   - res_flags_t : per-result flags {zero, underflow, src}
//   - MANT_W_DEF / EXP_W_DEF : default mantissa / exponent widths
//   - lz_w_of()   : leading-zero count width derived from the mantissa width
// -----------------------------------------------------------------------------
package fp_norm_pkg;

    localparam int MANT_W_DEF = 28;
    localparam int EXP_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic src;
    } res_flags_t;

    // Width needed to hold a leading-zero count of 0..mant_w-1.
    function automatic int lz_w_of(input int mant_w);
        return (mant_w > 1) ? $clog2(mant_w) : 1;
    endfunction

endpackage

// File: rtl/fp_norm_scheduler_if.sv
// -----------------------------------------------------------------------------
// fp_norm_scheduler_if
// Request and result handshakes of the normalization scheduler.
//   req0_*  : add/sub path request (valid/ready, mant, exp)
//   req1_*  : mul path request     (valid/ready, mant, exp)
//   out_*   : normalized result    (valid/ready, mant, exp, src, zero, underflow)
// Modports:
//   master : requesters + result consumer (drives requests, out_ready)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface fp_norm_scheduler_if
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
);

    logic              req0_valid;
    logic              req0_ready;
    logic [MANT_W-1:0] req0_mant;
    logic [EXP_W-1:0]  req0_exp;

    logic              req1_valid;
    logic              req1_ready;
    logic [MANT_W-1:0] req1_mant;
    logic [EXP_W-1:0]  req1_exp;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_src;
    logic              out_zero;
    logic              out_underflow;

    modport master (
        output req0_valid, req0_mant, req0_exp,
        output req1_valid, req1_mant, req1_exp,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_mant, out_exp, out_src, out_zero, out_underflow
    );

    modport slave (
        input  req0_valid, req0_mant, req0_exp,
        input  req1_valid, req1_mant, req1_exp,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_mant, out_exp, out_src, out_zero, out_underflow
    );

endinterface

// File: rtl/fp_norm_lod.sv
// -----------------------------------------------------------------------------
// fp_norm_lod
// Leading-one detector: marks the most significant set bit of vec_i.
//   vec_i    : input vector
//   onehot_o : one-hot vector of the leading one (all zero if vec_i == 0)
// Purely combinational.
// -----------------------------------------------------------------------------
module fp_norm_lod #(
    parameter int W = 28
) (
    input  logic [W-1:0] vec_i,
    output logic [W-1:0] onehot_o
);

    // above[i] is set when any bit strictly above position i is set.
    logic [W-1:0] above;

    assign above[W-1] = 1'b0;

    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_above
            assign above[gi] = |vec_i[W-1:gi+1];
        end
        for (genvar gi = 0; gi < W; gi++) begin : g_onehot
            assign onehot_o[gi] = vec_i[gi] & ~above[gi];
        end
    endgenerate

endmodule

// File: rtl/onehot_to_lz.sv
// -----------------------------------------------------------------------------
// onehot_to_lz
// Encodes a one-hot leading-one vector into the number of zeros above it.
//   onehot_i : one-hot vector (bit W-1 -> 0, bit 0 -> W-1)
//   lz_o     : leading-zero count; 0 when onehot_i is all zero
// Purely combinational.
// -----------------------------------------------------------------------------
module onehot_to_lz #(
    parameter int W    = 28,
    parameter int LZ_W = 5
) (
    input  logic [W-1:0]    onehot_i,
    output logic [LZ_W-1:0] lz_o
);

    // Each count bit is the OR of the one-hot positions whose count has that
    // bit set; valid because at most one input bit is high.
    generate
        for (genvar gi = 0; gi < LZ_W; gi++) begin : g_bit
            logic [W-1:0] sel;
            for (genvar gj = 0; gj < W; gj++) begin : g_pos
                assign sel[gj] = onehot_i[gj] & (((W - 1 - gj) >> gi) % 2 == 1);
            end
            assign lz_o[gi] = |sel;
        end
    endgenerate

endmodule

// File: rtl/fp_norm_scheduler.sv
// -----------------------------------------------------------------------------
// fp_norm_scheduler
// Shares one leading-one detector and left shifter between the add/sub path
// (port 0) and the mul path (port 1). Each accepted request is normalized,
// its exponent adjusted (clamped at zero with underflow flagged), and the
// result presented on a valid/ready output.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fp_norm_scheduler_if.slave (req0_*, req1_*, out_*)
// Flow: IDLE (accept) -> DETECT (count leading zeros) -> SHIFT (normalize)
//       -> DONE (hold result until out_ready) -> IDLE.
// -----------------------------------------------------------------------------
module fp_norm_scheduler
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_norm_scheduler_if.slave bus
);

    localparam int LZ_W = lz_w_of(MANT_W);

    state_e            state_q, state_d;

    // Captured request
    logic [MANT_W-1:0] mant_q;
    logic [EXP_W-1:0]  exp_q;
    logic              src_q;
    // Port served by the most recent handshake; the other port wins a tie.
    logic              last_q;

    // Detection results
    logic [LZ_W-1:0]   lz_q;
    logic              zero_q;

    // Output registers
    logic [MANT_W-1:0] out_mant_q, out_mant_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    res_flags_t        out_flags_q, out_flags_d;

    logic              grant;
    logic              in_idle;
    logic              hs;
    logic [MANT_W-1:0] lead_onehot;
    logic [LZ_W-1:0]   lz;

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        grant = ~last_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
    end

    assign in_idle = (state_q == IDLE);

    // Readies are held low while reset is asserted so every output is 0 then.
    assign bus.req0_ready = rst_n & in_idle & ~grant;
    assign bus.req1_ready = rst_n & in_idle &  grant;
    assign hs             = in_idle & (grant ? bus.req1_valid : bus.req0_valid);

    // ------------------------------------------------------ shared detection
    fp_norm_lod #(
        .W (MANT_W)
    ) u_lod (
        .vec_i    (mant_q),
        .onehot_o (lead_onehot)
    );

    onehot_to_lz #(
        .W    (MANT_W),
        .LZ_W (LZ_W)
    ) u_lz (
        .onehot_i (lead_onehot),
        .lz_o     (lz)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = DETECT;
            DETECT:  state_d = SHIFT;
            SHIFT:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------- normalize / clamp
    // Comparison is done one bit wider than the exponent so that lz never
    // wraps against a small exponent.
    logic [EXP_W:0] exp_ext;
    logic [EXP_W:0] lz_ext;

    assign exp_ext = {1'b0, exp_q};
    assign lz_ext  = (EXP_W + 1)'(lz_q);

    always_comb begin
        out_mant_d            = '0;
        out_exp_d             = '0;
        out_flags_d.zero      = 1'b0;
        out_flags_d.underflow = 1'b0;
        out_flags_d.src       = src_q;
        if (zero_q) begin
            out_flags_d.zero = 1'b1;
        end else if (exp_q == '0) begin
            // Already denormal: nothing to shift into.
            out_mant_d            = mant_q;
            out_flags_d.underflow = 1'b1;
        end else if (lz_ext < exp_ext) begin
            out_mant_d = mant_q << lz_q;
            out_exp_d  = exp_q - EXP_W'(lz_q);
        end else begin
            // Shift only as far as the exponent allows, landing on exp = 0.
            out_mant_d            = mant_q << (exp_q - EXP_W'(1));
            out_flags_d.underflow = 1'b1;
        end
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q      <= '0;
            exp_q       <= '0;
            src_q       <= 1'b0;
            last_q      <= 1'b1;
            lz_q        <= '0;
            zero_q      <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        mant_q <= grant ? bus.req1_mant : bus.req0_mant;
                        exp_q  <= grant ? bus.req1_exp  : bus.req0_exp;
                        src_q  <= grant;
                        last_q <= grant;
                    end
                end
                DETECT: begin
                    lz_q   <= lz;
                    zero_q <= ~|mant_q;
                end
                SHIFT: begin
                    out_mant_q  <= out_mant_d;
                    out_exp_q   <= out_exp_d;
                    out_flags_q <= out_flags_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_mant      = out_mant_q;
    assign bus.out_exp       = out_exp_q;
    assign bus.out_src       = out_flags_q.src;
    assign bus.out_zero      = out_flags_q.zero;
    assign bus.out_underflow = out_flags_q.underflow;

endmodule
